// File: rtl/sprite_move_engine.sv
// Sprite mover: for each start request it erases the sprite, moves it by a clamped step
// and draws it again, sending one plot pixel per cycle to the VGA adapter.
module sprite_move_engine #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int COL_W    = 3,
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int STEP     = 1,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int X_INIT   = 50,
  parameter int Y_INIT   = 50,
  parameter logic [COL_W-1:0] FG_COLOUR = 3'b100,
  parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       dir,
  output logic             busy,
  output logic             done,
  output logic [XW-1:0]    x_pos,
  output logic [YW-1:0]    y_pos,
  output logic [XW-1:0]    vga_x,
  output logic [YW-1:0]    vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             vga_plot
);

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_DONE} state_t;

  localparam logic [XW-1:0] XC_LAST = XW'(SPRITE_W - 1);
  localparam logic [YW-1:0] YC_LAST = YW'(SPRITE_H - 1);
  localparam logic [XW:0]   STEP_X  = (XW+1)'(STEP);
  localparam logic [YW:0]   STEP_Y  = (YW+1)'(STEP);
  localparam logic [XW:0]   XLIM    = (XW+1)'(X_MAX - SPRITE_W + 1);
  localparam logic [YW:0]   YLIM    = (YW+1)'(Y_MAX - SPRITE_H + 1);

  state_t          r_state, w_next;
  logic [XW-1:0]   r_xcnt, r_x, w_x_new;
  logic [YW-1:0]   r_ycnt, r_y, w_y_new;
  logic [3:0]      r_dir;
  logic            w_scan, w_last;
  logic [XW:0]     w_x_sum;
  logic [YW:0]     w_y_sum;

  assign w_scan  = (r_state == S_ERASE) || (r_state == S_DRAW);
  assign w_last  = (r_xcnt == XC_LAST) && (r_ycnt == YC_LAST);
  assign w_x_sum = {1'b0, r_x} + STEP_X;
  assign w_y_sum = {1'b0, r_y} + STEP_Y;

  // dir = {left, right, down, up}; opposing requests on an axis cancel
  always_comb begin
    w_x_new = r_x;
    w_y_new = r_y;
    case ({r_dir[3], r_dir[2]})
      2'b10:   w_x_new = ({1'b0, r_x} >= STEP_X) ? r_x - XW'(STEP) : '0;
      2'b01:   w_x_new = (w_x_sum <= XLIM) ? w_x_sum[XW-1:0] : XLIM[XW-1:0];
      default: w_x_new = r_x;
    endcase
    case ({r_dir[0], r_dir[1]})
      2'b10:   w_y_new = ({1'b0, r_y} >= STEP_Y) ? r_y - YW'(STEP) : '0;
      2'b01:   w_y_new = (w_y_sum <= YLIM) ? w_y_sum[YW-1:0] : YLIM[YW-1:0];
      default: w_y_new = r_y;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    vga_plot   = 1'b0;
    vga_colour = BG_COLOUR;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ERASE;
      S_ERASE: begin
        vga_plot = 1'b1;
        if (w_last) w_next = S_MOVE;
      end
      S_MOVE:  w_next = S_DRAW;
      S_DRAW:  begin
        vga_plot   = 1'b1;
        vga_colour = FG_COLOUR;
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_xcnt  <= '0;
      r_ycnt  <= '0;
      r_dir   <= '0;
      r_x     <= XW'(X_INIT);
      r_y     <= YW'(Y_INIT);
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_dir <= dir;
      if (w_scan) begin
        if (r_xcnt == XC_LAST) begin
          r_xcnt <= '0;
          r_ycnt <= (r_ycnt == YC_LAST) ? '0 : r_ycnt + YW'(1);
        end else begin
          r_xcnt <= r_xcnt + XW'(1);
        end
      end
      if (r_state == S_MOVE) begin
        r_x <= w_x_new;
        r_y <= w_y_new;
      end
    end
  end

  assign x_pos = r_x;
  assign y_pos = r_y;
  assign vga_x = r_x + r_xcnt;
  assign vga_y = r_y + r_ycnt;

endmodule

// File: doc/sprite_move_engine.md
Name: sprite_move_engine

Overview:
Parametrised successor to the single-sprite movement datapath. On each start request it erases the sprite at its current origin, applies a clamped move of STEP pixels in the requested direction(s), and redraws the sprite, streaming one pixel per cycle to the VGA adapter's plot interface. Sprite size, step, screen bounds, colours and start position are parameters, and diagonal moves are supported. A done/busy handshake replaces the control-code-driven datapath; it sits between the game FSM and the VGA adapter.

Parameters:
XW, 8, x coordinate width
YW, 7, y coordinate width
COL_W, 3, colour width
SPRITE_W, 4, sprite width in pixels (1..2^XW)
SPRITE_H, 4, sprite height in pixels (1..2^YW)
STEP, 1, pixels moved per axis per request
X_MAX, 159, last visible column
Y_MAX, 119, last visible row
X_INIT, 50, origin x after reset
Y_INIT, 50, origin y after reset
FG_COLOUR, 3'b100, sprite colour
BG_COLOUR, 3'b000, erase colour

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  move/redraw request, sampled only in IDLE
dir  in  4  {left,right,down,up}, sampled with start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on operation completion
x_pos  out  XW  current sprite origin x (registered)
y_pos  out  YW  current sprite origin y (registered)
vga_x  out  XW  pixel x = x_pos + xcnt
vga_y  out  YW  pixel y = y_pos + ycnt
vga_colour  out  COL_W  BG_COLOUR in ERASE, FG_COLOUR in DRAW, else BG_COLOUR
vga_plot  out  1  high exactly in ERASE and DRAW

Behaviour:
- Reset (async, immediate): state IDLE; x_pos=X_INIT, y_pos=Y_INIT; xcnt=ycnt=0; dir latch=0; busy=0, done=0, vga_plot=0, vga_colour=BG_COLOUR. Reset mid-scan aborts the scan; no further pixels are plotted.
- States: IDLE -> ERASE -> MOVE -> DRAW -> DONE -> IDLE.
- IDLE: start=1 at a clock edge latches dir and enters ERASE; counters are 0. start=0 holds IDLE.
- ERASE/DRAW: one pixel per cycle, row-major (xcnt inner). At xcnt=SPRITE_W-1, xcnt wraps to 0 and ycnt increments. At the last pixel (SPRITE_W-1, SPRITE_H-1) both counters clear and the next state is taken. Each phase lasts exactly SPRITE_W*SPRITE_H cycles.
- vga_x/vga_y/vga_colour/vga_plot are combinational from registered state, counters and position. The pixel is valid in the same cycle it is presented.
- MOVE (1 cycle, plot low), with XLIM = X_MAX-SPRITE_W+1 and YLIM = Y_MAX-SPRITE_H+1:
  - left only: x = (x>=STEP) ? x-STEP : 0
  - right only: x = (x+STEP<=XLIM) ? x+STEP : XLIM
  - left and right together, or neither: x unchanged. Vertical axis uses up/down the same way with YLIM.
  - Sums are computed one bit wider than XW/YW so no wrap-around occurs.
- DONE: done=1 for one cycle, busy still 1, then IDLE. A start arriving in IDLE on the following edge is accepted, so back-to-back requests are possible.
- Latency: start edge to done high = 2*SPRITE_W*SPRITE_H + 1 cycles. busy is high for 2*W*H+2 cycles.
- start and dir changes while busy are ignored. dir=0 performs an erase and redraw in place, which is also used for the initial draw after reset.
- x_pos/y_pos change only on the MOVE->DRAW edge.

Test Plan:
- Reset, then start with dir=0 -> 16 BG pixels (50..53, 50..53) row-major, one idle cycle, then 16 FG pixels at the same coordinates; done pulses at cycle 34 after start; x_pos/y_pos stay 50/50.
- Origin 50,50, start dir=right|down -> erase at 50..53 × 50..53, draw at 51..54 × 51..54; x_pos=51, y_pos=51 after MOVE.
- Origin forced to 0,0 via repeated left|up, then start dir=left|up -> origin stays 0,0; a redraw still occurs and done pulses.
- Drive right 120 times -> x_pos saturates at 156 and the last drawn column is 159, never beyond. Likewise down saturates at y_pos=116.
- dir=left|right -> x unchanged. start pulsed during DRAW -> ignored; no second operation and busy drops after done.
- reset_n low at pixel 7 of DRAW -> vga_plot falls immediately, state IDLE, position returns to 50,50, done never pulses.
